// File: rtl/pseudoinverse_pkg.sv
// -----------------------------------------------------------------------------
// pseudoinverse_pkg
// Shared definitions for the pseudo-inverse datapath blocks (row shifter on
// the transmit side, word_packer on the receive side).
//   - ROW_BITS / WORD_BITS : default row and serial word widths
//   - state_t, ST_FILL/ST_FULL : two-state collector encoding
//   - clog2()              : constant-foldable ceiling log2 for port widths
// -----------------------------------------------------------------------------
package pseudoinverse_pkg;

  localparam int ROW_BITS  = 128;
  localparam int WORD_BITS = 32;

  typedef logic state_t;

  localparam state_t ST_FILL = 1'b0;
  localparam state_t ST_FULL = 1'b1;

  // Ceiling log2; clog2(1) = 0, clog2(5) = 3. Used to size counters that must
  // hold the value K itself, so callers pass K+1.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

endpackage : pseudoinverse_pkg

// File: rtl/word_packer.sv
// -----------------------------------------------------------------------------
// word_packer
// Serial-to-parallel collector. Accepts nBits-wide words one per handshake and
// assembles K = M/nBits of them into an M-bit row. The first word of a row
// ends up in the most-significant slice Data_out[M-1:M-nBits], matching the
// word order of the row shifter.
//
// Ports
//   clock      : rising-edge clock
//   reset      : asynchronous active-low reset
//   clear      : synchronous flush of a partial or complete row
//   in_valid   : Data_in holds a word
//   in_ready   : block accepts a word this cycle
//   Data_in    : serial word
//   out_valid  : Data_out holds a complete row
//   out_ready  : consumer takes the row this cycle
//   Data_out   : assembly register (partial row while filling)
//   word_count : words currently held, 0..K
// -----------------------------------------------------------------------------
module word_packer
  import pseudoinverse_pkg::*;
#(
  parameter int M     = ROW_BITS,
  parameter int nBits = WORD_BITS
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [0:nBits-1]               Data_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [M-1:0]                   Data_out,
  output logic [clog2(M/nBits+1)-1:0]    word_count
);

  localparam int K  = M / nBits;
  localparam int CW = clog2(K + 1);

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(K);

  // A row must split into whole words, and a one-word "row" would make the
  // FULL/FILL handover degenerate.
  generate
    if (((M % nBits) != 0) || (K < 2)) begin : g_param_check
      $error("word_packer: M (%0d) must be a multiple of nBits (%0d) with at least 2 words per row",
             M, nBits);
    end
  endgenerate

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M-1:0]   row_q, row_d;

  logic           in_acc_s;
  logic           out_acc_s;
  logic [M-1:0]   row_shift_s;

  // Newest word enters at the bottom, so the oldest word drifts to the top.
  assign row_shift_s = {row_q[M-nBits-1:0], Data_in};

  // Handshakes; clear forces in_ready/out_valid low, so neither can fire then.
  assign in_acc_s  = in_valid  & in_ready;
  assign out_acc_s = out_valid & out_ready;

  assign Data_out   = row_q;
  assign word_count = cnt_q;

  // State, count and assembly register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FILL;
      cnt_q   <= CNT_ZERO;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end

  // Next-state, next-count and next-row logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    if (clear) begin
      // Flush drops the count but leaves the register contents alone.
      state_d = ST_FILL;
      cnt_d   = CNT_ZERO;
      row_d   = row_q;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (in_acc_s) begin
            row_d = row_shift_s;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == (CNT_FULL - CNT_ONE)) begin
              state_d = ST_FULL;
            end else begin
              state_d = ST_FILL;
            end
          end else begin
            state_d = ST_FILL;
          end
        end
        ST_FULL: begin
          if (out_acc_s) begin
            state_d = ST_FILL;
            if (in_acc_s) begin
              // Same-cycle handover: this word starts the next row.
              row_d = row_shift_s;
              cnt_d = CNT_ONE;
            end else begin
              cnt_d = CNT_ZERO;
            end
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_FILL;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Handshake outputs decoded from state; in FULL, in_ready follows out_ready
  // so a word can only enter while the held row is leaving.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (clear) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          in_ready  = 1'b1;
          out_valid = 1'b0;
        end
        ST_FULL: begin
          in_ready  = out_ready;
          out_valid = 1'b1;
        end
        default: begin
          in_ready  = 1'b0;
          out_valid = 1'b0;
        end
      endcase
    end
  end

endmodule : word_packer

// File: tb/tb_word_packer.sv
module tb_word_packer;

  logic         clock;
  logic         reset;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  din;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] Data_out;
  logic [2:0]   word_count;

  int vectors;
  int miscompares;
  logic [127:0] exp_q[$];

  word_packer #(.M(128), .nBits(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Data_in    (din),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Data_out   (Data_out),
    .word_count (word_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard: every row handshake pops the oldest expected row.
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL row_pop: got unexpected row %h, want no row", Data_out);
      end else begin
        logic [127:0] exp_row;
        exp_row = exp_q.pop_front();
        if (Data_out !== exp_row) begin
          miscompares++;
          $display("FAIL row_data: got %h, want %h", Data_out, exp_row);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = 32'h0;
    #12;
    vectors++;
    if (Data_out !== 128'h0 || word_count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_values: got data=%h cnt=%0d ov=%b ir=%b, want 0/0/0/1",
               Data_out, word_count, out_valid, in_ready);
    end
    step();
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if (word_count !== 3'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL after_release: got cnt=%0d ov=%b, want 0/0", word_count, out_valid);
    end
    step();
  endtask

  task automatic test_fill_hold();
    logic [31:0] w[4];
    w[0] = 32'h11111111; w[1] = 32'h22222222; w[2] = 32'h33333333; w[3] = 32'h44444444;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din = w[i]; in_valid = 1'b1;
      @(negedge clock);
      vectors++;
      if (in_ready !== 1'b1 || word_count !== 3'(i)) begin
        miscompares++;
        $display("FAIL fill_count: got ir=%b cnt=%0d, want 1/%0d", in_ready, word_count, i);
      end
      step();
    end
    // Keep offering a word while the row is held: it must be refused.
    din = 32'hDEADBEEF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || word_count !== 3'd4 ||
          Data_out !== 128'h11111111_22222222_33333333_44444444) begin
        miscompares++;
        $display("FAIL full_hold: got ov=%b ir=%b cnt=%0d data=%h, want 1/0/4/%h",
                 out_valid, in_ready, word_count, Data_out,
                 128'h11111111_22222222_33333333_44444444);
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_consume_and_fill();
    exp_q.push_back(128'h11111111_22222222_33333333_44444444);
    out_ready = 1'b1; in_valid = 1'b1; din = 32'h55555555;
    @(negedge clock);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL handover_ready: got ir=%b, want 1", in_ready);
    end
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    vectors++;
    if (word_count !== 3'd1 || Data_out[31:0] !== 32'h55555555 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL handover_next: got cnt=%0d low=%h ov=%b, want 1/55555555/0",
               word_count, Data_out[31:0], out_valid);
    end
    step();
    exp_q.push_back(128'h55555555_66666666_77777777_88888888);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; din = 32'h66666666 + 32'(i) * 32'h11111111;
      step();
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int pulses;
    int pulse_at[$];
    int stalls;
    pulses = 0; stalls = 0;
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back({32'hA0000000 + 32'(4*r), 32'hA0000001 + 32'(4*r),
                       32'hA0000002 + 32'(4*r), 32'hA0000003 + 32'(4*r)});
    end
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      in_valid = (c < 12);
      din = (c < 12) ? 32'hA0000000 + 32'(c) : 32'h0;
      @(negedge clock);
      if (out_valid) begin
        pulses++;
        pulse_at.push_back(c);
      end
      if (in_valid && !in_ready) stalls++;
      step();
    end
    in_valid = 1'b0;
    vectors++;
    if (pulses !== 3) begin
      miscompares++;
      $display("FAIL stream_pulses: got %0d, want 3", pulses);
    end
    vectors++;
    if (stalls !== 0) begin
      miscompares++;
      $display("FAIL stream_bubbles: got %0d stalled cycles, want 0", stalls);
    end
    if (pulse_at.size() == 3) begin
      vectors++;
      if (pulse_at[0] !== 4 || pulse_at[1] !== 8 || pulse_at[2] !== 12) begin
        miscompares++;
        $display("FAIL stream_spacing: got cycles %0d,%0d,%0d, want 4,8,12",
                 pulse_at[0], pulse_at[1], pulse_at[2]);
      end
    end
  endtask

  task automatic test_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; din = 32'hBAD00001 + 32'(i);
      step();
    end
    clear = 1'b1; in_valid = 1'b1; din = 32'hBAD00003;
    @(negedge clock);
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_outputs: got ir=%b ov=%b, want 0/0", in_ready, out_valid);
    end
    step();
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    vectors++;
    if (word_count !== 3'd0) begin
      miscompares++;
      $display("FAIL clear_count: got %0d, want 0", word_count);
    end
    exp_q.push_back(128'hC0000001_C0000002_C0000003_C0000004);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; din = 32'hC0000001 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    @(negedge clock);
    vectors++;
    if (word_count !== 3'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_row_done: got cnt=%0d ov=%b, want 0/0", word_count, out_valid);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; din = 32'hD0000001 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (word_count !== 3'd0 || Data_out !== 128'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: got cnt=%0d data=%h ov=%b ir=%b, want 0/0/0/1",
               word_count, Data_out, out_valid, in_ready);
    end
    step();
    reset = 1'b1;
    exp_q.push_back(128'hE0000001_E0000002_E0000003_E0000004);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; din = 32'hE0000001 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_gaps();
    logic [6:0] pattern;
    int exp_cnt[7];
    int k;
    pattern = 7'b1001101;
    exp_cnt[0] = 1; exp_cnt[1] = 1; exp_cnt[2] = 1; exp_cnt[3] = 2;
    exp_cnt[4] = 3; exp_cnt[5] = 3; exp_cnt[6] = 4;
    k = 0;
    exp_q.push_back(128'hF0000001_F0000002_F0000003_F0000004);
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      in_valid = pattern[6-c];
      if (pattern[6-c]) begin
        din = 32'hF0000001 + 32'(k);
        k++;
      end else begin
        din = 32'hDEADBEEF;
      end
      step();
      vectors++;
      if (word_count !== 3'(exp_cnt[c])) begin
        miscompares++;
        $display("FAIL gap_count: cycle %0d got %0d, want %0d", c, word_count, exp_cnt[c]);
      end
    end
    in_valid = 1'b0;
    @(negedge clock);
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL gap_complete: got ov=%b, want 1", out_valid);
    end
    step();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_fill_hold();
    test_consume_and_fill();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_gaps();
    step();
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL rows_outstanding: got %0d undelivered rows, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_word_packer

// File: doc/word_packer.md
# word_packer

Serial-to-parallel collector: accepts `nBits`-wide words one per handshake and assembles `K = M/nBits` of them into one `M`-bit row. It is the receive-side counterpart of the row shifter used in the pseudo-inverse datapath. Word order matches the shifter: the first word accepted lands in the most-significant slice `Data_out[M-1:M-nBits]`. Sits between the serial matrix-element stream and the row-wide consumers, with valid/ready flow control on both sides.

## Interface

- `M`, 128: assembled row width in bits; must be an integer multiple of `nBits`.
- `nBits`, 32: serial word width in bits.
- `clock` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `clear` input 1: synchronous flush; discards a partial or complete row.
- `in_valid` input 1: `Data_in` holds a word.
- `in_ready` output 1: block can accept a word this cycle.
- `Data_in` input `nBits` `[0:nBits-1]`: serial word.
- `out_valid` output 1: `Data_out` holds a complete row.
- `out_ready` input 1: consumer takes the row this cycle.
- `Data_out` output `M` `[M-1:0]`: assembled row.
- `word_count` output `clog2(K+1)`: number of words currently held, 0..K.

## Operation

- Input accept: `in_valid & in_ready`. Output accept: `out_valid & out_ready`.
- Two states:
  - FILL: `out_valid=0`, `in_ready=1`.
    - On accept: `r <= {r[M-nBits-1:0], Data_in}` and `word_count++`.
    - On the accept that makes `word_count==K`, go to FULL.
  - FULL: `out_valid=1`, `in_ready=out_ready` (combinational pass-through).
    - On output accept with no input accept: `word_count <= 0`, go to FILL.
    - On output accept with input accept in the same cycle: the word is shifted in as the first word of the next row, `word_count <= 1`, go to FILL.
    - With no output accept, the row and count hold.
- `Data_out` is the assembly register `r`. It is only meaningful while `out_valid=1`; during FILL it shows the partial row.
- `clear`:
  - Overrides all other activity: `word_count <= 0`, state goes to FILL, `r` is left unchanged.
  - No input or output accept counts in a `clear` cycle. `in_ready` and `out_valid` are forced to 0 in that cycle.
- `Data_in` values are never modified; no arithmetic on data.
- Elaboration-time check: `M % nBits == 0` and `K >= 2`. Otherwise, fail with `$error`.

## Timing

- Reset values, asserted immediately on the falling edge of `reset`:
  - state FILL
  - `r=0`, so `Data_out=0`
  - `word_count=0`
  - `out_valid=0`
  - `in_ready=1`: combinational from state. No accept can occur while `reset=0`.
- Latency:
  - `out_valid` rises on the rising edge that accepts word K. This is 0 cycles after the last input handshake: visible the next cycle.
  - With `in_valid` held high and `out_ready` high, throughput is one row every K cycles with no bubble.
- `in_ready` depends combinationally on `out_ready` only in FULL; there is no combinational path from `in_valid`.
- Reset mid-row: the partial row is dropped; after release the first accepted word is word 1.
- `out_ready` without `out_valid`, or `in_valid` without `in_ready`: no effect.

## Structure

- Shared package `pseudoinverse_pkg` holds:
  - the `clog2` function
  - the state encoding constants `ST_FILL`, `ST_FULL`
  - default widths `ROW_BITS=128`, `WORD_BITS=32`, shared with the shifter.
- Single module, no sub-modules. The counter and the two-state controller are small enough to stay inline.

## Test plan

- Reset, then 4 words `11111111`, `22222222`, `33333333`, `44444444` back-to-back, with `out_ready=0`:
  - `out_valid=1` after word 4.
  - `Data_out=128'h11111111_22222222_33333333_44444444`.
  - `word_count=4`, `in_ready=0`; the row holds for 5 cycles.
- Continue from that FULL state: assert `out_ready` with `in_valid` and word `55555555` in the same cycle.
  - Row consumed.
  - Next cycle: `word_count=1`, `Data_out[31:0]=55555555`, `out_valid=0`.
- Continuous stream of 12 words with `out_ready=1`:
  - Exactly 3 `out_valid` pulses, 4 cycles apart.
  - Each row is correct.
  - No word is lost.
- Feed 2 words, then pulse `clear`:
  - `word_count=0`.
  - The next 4 words form a row containing only those 4.
- Assert `reset=0` asynchronously mid-row, after 3 words:
  - Outputs go to reset values before the next clock edge.
  - After release, 4 fresh words produce a correct row.
- Gaps in `in_valid` (pattern 1,0,0,1,1,0,1):
  - Only valid cycles are counted.
  - Row completes on the 4th valid word.
